// File: rtl/pong_scan.sv
// Raster scan generator and object renderer for the pong field.
// Walks a 128x128 signed field plus blanking and classifies each active pixel against a per-frame game-state snapshot.
module pong_scan #(
    parameter int unsigned H_BLANK     = 32,
    parameter int unsigned V_BLANK     = 8,
    parameter int unsigned BALL_HALF   = 1,
    parameter int unsigned PADDLE_HALF = 4,
    parameter int unsigned PADDLE_X    = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [7:0] ball_x,
    input  logic signed [7:0] ball_y,
    input  logic signed [7:0] paddle_p1,
    input  logic signed [7:0] paddle_p2,
    output logic              frame_tick,
    output logic              pixel_valid,
    output logic signed [7:0] pixel_x,
    output logic signed [7:0] pixel_y,
    output logic [1:0]        pixel_kind,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = 128 + H_BLANK;
    localparam int unsigned V_TOTAL = 128 + V_BLANK;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);

    localparam logic signed [8:0] BH     = 9'(BALL_HALF);
    localparam logic signed [8:0] PH     = 9'(PADDLE_HALF);
    localparam logic signed [7:0] P1_COL = 8'(0 - PADDLE_X);
    localparam logic signed [7:0] P2_COL = 8'(PADDLE_X - 1);

    localparam logic [1:0] KIND_BG     = 2'd0;
    localparam logic [1:0] KIND_NET    = 2'd1;
    localparam logic [1:0] KIND_PADDLE = 2'd2;
    localparam logic [1:0] KIND_BALL   = 2'd3;

    logic [HW-1:0] h, h_nxt_c;
    logic [VW-1:0] v, v_nxt_c;
    logic          h_last_c, v_last_c, active_c;

    logic signed [7:0] sb_x, sb_y, sp1, sp2;

    logic signed [7:0] cur_x_c, cur_y_c;
    logic signed [8:0] dbx_c, dby_c, dp1_c, dp2_c;
    logic              ball_hit_c, paddle_hit_c, net_hit_c;
    logic [1:0]        kind_c;

    // Raster counters: h wraps each line, v advances on h wrap.
    always_comb begin
        h_last_c = (h == HW'(H_TOTAL - 1));
        v_last_c = (v == VW'(V_TOTAL - 1));
        h_nxt_c  = h + HW'(1);
        v_nxt_c  = v;
        if (h_last_c) begin
            h_nxt_c = '0;
            v_nxt_c = v_last_c ? '0 : v + VW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_nxt_c;
            v <= v_nxt_c;
        end
    end

    // Game state is latched on the final cycle of a frame so the next frame renders tear-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_x <= '0;
            sb_y <= '0;
            sp1  <= '0;
            sp2  <= '0;
        end else if (h_last_c && v_last_c) begin
            sb_x <= ball_x;
            sb_y <= ball_y;
            sp1  <= paddle_p1;
            sp2  <= paddle_p2;
        end
    end

    // Hit tests at 9-bit signed width so objects near the edges clip instead of wrapping.
    always_comb begin
        active_c = (h < HW'(128)) && (v < VW'(128));
        cur_x_c  = {1'b0, h[6:0]} - 8'd64;
        cur_y_c  = {1'b0, v[6:0]} - 8'd64;
        dbx_c    = {cur_x_c[7], cur_x_c} - {sb_x[7], sb_x};
        dby_c    = {cur_y_c[7], cur_y_c} - {sb_y[7], sb_y};
        dp1_c    = {cur_y_c[7], cur_y_c} - {sp1[7], sp1};
        dp2_c    = {cur_y_c[7], cur_y_c} - {sp2[7], sp2};

        ball_hit_c   = (dbx_c >= -BH) && (dbx_c <= BH) &&
                       (dby_c >= -BH) && (dby_c <= BH);
        paddle_hit_c = ((cur_x_c == P1_COL) && (dp1_c >= -PH) && (dp1_c <= PH)) ||
                       ((cur_x_c == P2_COL) && (dp2_c >= -PH) && (dp2_c <= PH));
        net_hit_c    = (cur_x_c == 8'sd0) && !v[2];

        kind_c = KIND_BG;
        if (ball_hit_c) begin
            kind_c = KIND_BALL;
        end else if (paddle_hit_c) begin
            kind_c = KIND_PADDLE;
        end else if (net_hit_c) begin
            kind_c = KIND_NET;
        end
    end

    // One-cycle registered view of the counter state; blanking drives zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick  <= 1'b0;
            frame_start <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_kind  <= KIND_BG;
        end else begin
            frame_tick  <= (h == '0) && (v == VW'(128));
            frame_start <= (h == '0) && (v == '0);
            pixel_valid <= active_c;
            pixel_x     <= active_c ? cur_x_c : 8'sd0;
            pixel_y     <= active_c ? cur_y_c : 8'sd0;
            pixel_kind  <= active_c ? kind_c : KIND_BG;
        end
    end

endmodule

// File: tb/tb_pong_scan.sv
// Bench for pong_scan: position-based reference model checked every cycle, plus per-frame object statistics
// compared against hand-derived values for the directed scenarios.
`timescale 1ns/1ps
module tb_pong_scan;

    localparam int HT  = 160;
    localparam int VT  = 136;
    localparam int PER = HT * VT;

    localparam int S_VALID = 0;
    localparam int S_NET   = 1;
    localparam int S_BALL  = 2;
    localparam int S_BXLO  = 3;
    localparam int S_BXHI  = 4;
    localparam int S_BYLO  = 5;
    localparam int S_BYHI  = 6;
    localparam int S_P1    = 7;
    localparam int S_P1LO  = 8;
    localparam int S_P1HI  = 9;
    localparam int S_P2    = 10;
    localparam int S_P2LO  = 11;
    localparam int S_P2HI  = 12;
    localparam int NS      = 13;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic signed [7:0] ball_x = '0, ball_y = '0, paddle_p1 = '0, paddle_p2 = '0;
    logic              frame_tick, pixel_valid, frame_start;
    logic signed [7:0] pixel_x, pixel_y;
    logic [1:0]        pixel_kind;

    int total = 0;
    int bad   = 0;

    pong_scan #(
        .H_BLANK(32), .V_BLANK(8), .BALL_HALF(1), .PADDLE_HALF(4), .PADDLE_X(60)
    ) dut (
        .clk(clk), .reset(reset),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_p1(paddle_p1), .paddle_p2(paddle_p2),
        .frame_tick(frame_tick), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_kind(pixel_kind),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Reference: frame position counted from reset, outputs derived from field geometry.
    int pos = 0, sbx = 0, sby = 0, s1 = 0, s2 = 0;
    int mh, mv, mx, my;
    int m_valid = 0, m_tick = 0, m_fs = 0, m_x = 0, m_y = 0, m_kind = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos = 0; sbx = 0; sby = 0; s1 = 0; s2 = 0;
            m_valid = 0; m_tick = 0; m_fs = 0; m_x = 0; m_y = 0; m_kind = 0;
        end else begin
            mh = pos % HT;
            mv = pos / HT;
            mx = mh - 64;
            my = mv - 64;
            m_valid = (mh < 128 && mv < 128) ? 1 : 0;
            m_tick  = (mh == 0 && mv == 128) ? 1 : 0;
            m_fs    = (pos == 0) ? 1 : 0;
            m_x = 0; m_y = 0; m_kind = 0;
            if (m_valid == 1) begin
                m_x = mx;
                m_y = my;
                if (iabs(mx - sbx) <= 1 && iabs(my - sby) <= 1)
                    m_kind = 3;
                else if ((mx == -60 && iabs(my - s1) <= 4) || (mx == 59 && iabs(my - s2) <= 4))
                    m_kind = 2;
                else if (mx == 0 && ((my + 64) & 4) == 0)
                    m_kind = 1;
            end
            if (pos == PER - 1) begin
                sbx = int'(ball_x); sby = int'(ball_y);
                s1  = int'(paddle_p1); s2 = int'(paddle_p2);
            end
            pos = (pos + 1) % PER;
        end
    end

    int cyc = 0, last_tick = -1, fs_count = 0;
    int px, py;
    int cur[NS];
    int last[NS];

    task automatic clear_cur();
        for (int i = 0; i < NS; i++) cur[i] = 0;
        cur[S_BXLO] = 999; cur[S_BXHI] = -999;
        cur[S_BYLO] = 999; cur[S_BYHI] = -999;
        cur[S_P1LO] = 999; cur[S_P1HI] = -999;
        cur[S_P2LO] = 999; cur[S_P2HI] = -999;
    endtask

    initial clear_cur();

    // Per-cycle compare plus frame statistics gathered from the DUT outputs.
    always @(negedge clk) begin
        check("valid", int'(pixel_valid), m_valid);
        check("tick", int'(frame_tick), m_tick);
        check("fstart", int'(frame_start), m_fs);
        check("px", int'(pixel_x), m_x);
        check("py", int'(pixel_y), m_y);
        check("kind", int'(pixel_kind), m_kind);
        if (!reset) begin
            cyc = 0;
            last_tick = -1;
        end else begin
            cyc++;
            if (frame_tick) begin
                if (last_tick >= 0) check("tick_period", cyc - last_tick, 21760);
                last_tick = cyc;
            end
            if (frame_start) begin
                last = cur;
                fs_count++;
                clear_cur();
            end
            if (pixel_valid) begin
                px = int'(pixel_x);
                py = int'(pixel_y);
                cur[S_VALID]++;
                if (pixel_kind == 2'd1) cur[S_NET]++;
                if (pixel_kind == 2'd3) begin
                    cur[S_BALL]++;
                    if (px < cur[S_BXLO]) cur[S_BXLO] = px;
                    if (px > cur[S_BXHI]) cur[S_BXHI] = px;
                    if (py < cur[S_BYLO]) cur[S_BYLO] = py;
                    if (py > cur[S_BYHI]) cur[S_BYHI] = py;
                end
                if (pixel_kind == 2'd2 && px == -60) begin
                    cur[S_P1]++;
                    if (py < cur[S_P1LO]) cur[S_P1LO] = py;
                    if (py > cur[S_P1HI]) cur[S_P1HI] = py;
                end
                if (pixel_kind == 2'd2 && px == 59) begin
                    cur[S_P2]++;
                    if (py < cur[S_P2LO]) cur[S_P2LO] = py;
                    if (py > cur[S_P2HI]) cur[S_P2HI] = py;
                end
            end
        end
    end

    task automatic wait_fs();
        int target;
        target = fs_count + 1;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk); #1;
            if (fs_count >= target) break;
        end
        check("frame_start_timeout", fs_count, target);
    endtask

    task automatic noise(input int n);
        repeat (n) begin
            repeat ($urandom_range(100, 600)) @(negedge clk);
            #1;
            ball_x    = 8'($urandom);
            ball_y    = 8'($urandom);
            paddle_p1 = 8'($urandom);
            paddle_p2 = 8'($urandom);
        end
    endtask

    task automatic set_state(input int bx, input int by, input int p1, input int p2);
        ball_x = 8'(bx); ball_y = 8'(by); paddle_p1 = 8'(p1); paddle_p2 = 8'(p2);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #1;
        check("first_valid", int'(pixel_valid), 1);
        check("first_fstart", int'(frame_start), 1);
        check("first_x", int'(pixel_x), -64);
        check("first_y", int'(pixel_y), -64);

        // Frame 0 renders with an all-zero snapshot; inputs may churn freely.
        noise(20);
        set_state(0, 0, 10, -64);
        wait_fs();
        check("f0_valid_count", last[S_VALID], 16384);
        check("f0_ball_count", last[S_BALL], 9);
        check("f0_ball_xlo", last[S_BXLO], -1);
        check("f0_ball_xhi", last[S_BXHI], 1);
        check("f0_ball_ylo", last[S_BYLO], -1);
        check("f0_ball_yhi", last[S_BYHI], 1);
        check("f0_net_count", last[S_NET], 62);
        check("f0_p1_count", last[S_P1], 9);

        // Frame 1: paddles at 10 / -64; ball_x moves mid-frame but must not show yet.
        noise(10);
        set_state(0, 0, 10, -64);
        repeat (4000) @(negedge clk);
        #1 ball_x = 8'sd20;
        wait_fs();
        check("f1_p1_count", last[S_P1], 9);
        check("f1_p1_lo", last[S_P1LO], 6);
        check("f1_p1_hi", last[S_P1HI], 14);
        check("f1_p2_count", last[S_P2], 5);
        check("f1_p2_lo", last[S_P2LO], -64);
        check("f1_p2_hi", last[S_P2HI], -60);
        check("f1_ball_xlo", last[S_BXLO], -1);
        check("f1_ball_xhi", last[S_BXHI], 1);
        check("f1_ball_count", last[S_BALL], 9);

        // Frame 2 shows the moved ball; arrange a corner ball for frame 3.
        noise(10);
        set_state(63, -64, 10, -64);
        wait_fs();
        check("f2_ball_xlo", last[S_BXLO], 19);
        check("f2_ball_xhi", last[S_BXHI], 21);
        check("f2_ball_count", last[S_BALL], 9);

        // Corner ball occupies only the first two lines of frame 3.
        repeat (4 * HT) @(negedge clk);
        #1;
        check("f3_ball_count", cur[S_BALL], 4);
        check("f3_ball_xlo", cur[S_BXLO], 62);
        check("f3_ball_xhi", cur[S_BXHI], 63);
        check("f3_ball_ylo", cur[S_BYLO], -64);
        check("f3_ball_yhi", cur[S_BYHI], -63);

        for (int i = 0; i < 200; i++) begin
            if (pixel_valid && pixel_x != 8'sd0) break;
            @(negedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_x", int'(pixel_x), 0);
        check("rst_y", int'(pixel_y), 0);
        check("rst_kind", int'(pixel_kind), 0);
        check("rst_fstart", int'(frame_start), 0);
        set_state(33, -20, 7, 9);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #1;
        check("rel_valid", int'(pixel_valid), 1);
        check("rel_fstart", int'(frame_start), 1);
        check("rel_x", int'(pixel_x), -64);
        check("rel_y", int'(pixel_y), -64);
        check("rel_kind", int'(pixel_kind), 0);
        noise(5);
        repeat (200) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
